// File: rtl/snake_engine.sv
// snake_engine: grid snake core with segment store, move and collision FSM,
// LFSR food placement and a registered per-cell pixel query.
// Ports: clk_100MHz, reset (sync, active-high), direction one-hot
// {up,down,left,right}, start pulse, query_x/query_y -> q_snake/q_head/q_food,
// head_x/head_y, food_x/food_y, snake_length, score, move_strobe, game_over.
module snake_engine #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 20,
  parameter int MAX_LEN  = 64,
  parameter int TICK_DIV = 10_000_000,
  parameter bit WRAP     = 1'b1,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic [3:0]    direction,
  input  logic          start,
  input  logic [XW-1:0] query_x,
  input  logic [YW-1:0] query_y,
  output logic          q_snake,
  output logic          q_head,
  output logic          q_food,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [XW-1:0] food_x,
  output logic [YW-1:0] food_y,
  output logic [LW-1:0] snake_length,
  output logic [15:0]   score,
  output logic          move_strobe,
  output logic          game_over
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [15:0] SEED = 16'hACE1;

  // Encoding chosen so that the reverse heading is h ^ 1.
  localparam logic [1:0] H_UP    = 2'd0;
  localparam logic [1:0] H_DOWN  = 2'd1;
  localparam logic [1:0] H_LEFT  = 2'd2;
  localparam logic [1:0] H_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PLACE,
    S_OVER
  } state_t;

  state_t        state_q;
  logic [1:0]    heading_q;
  logic [1:0]    dir_cand;
  logic          dir_load;
  logic [CW-1:0] cnt_q;
  logic          tick;
  logic          pend_q;
  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_nx;

  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];

  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [XW-1:0] cand_x;
  logic [YW-1:0] cand_y;
  logic          wall;
  logic          eat;
  logic          body_hit;
  logic          cand_hit;
  logic          cand_ok;
  logic          query_hit;
  logic          board_full;
  logic          restart;

  assign head_x    = seg_x[0];
  assign head_y    = seg_y[0];
  assign game_over = (state_q == S_OVER);

  assign lfsr_nx = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign cand_x = lfsr_q[XW-1:0];
  assign cand_y = lfsr_q[XW+YW-1:XW];

  assign tick       = (cnt_q == CW'(TICK_DIV - 1));
  assign eat        = (nx == food_x) && (ny == food_y);
  assign board_full = (int'(snake_length) == GRID_W * GRID_H);
  assign restart    = (state_q == S_OVER) && start;
  assign cand_ok    = (int'(cand_x) < GRID_W) &&
                      (int'(cand_y) < GRID_H) && !cand_hit;

  always_comb begin
    dir_cand = heading_q;
    if ($onehot(direction)) begin
      unique case (1'b1)
        direction[3]: dir_cand = H_UP;
        direction[2]: dir_cand = H_DOWN;
        direction[1]: dir_cand = H_LEFT;
        direction[0]: dir_cand = H_RIGHT;
        default:      dir_cand = heading_q;
      endcase
    end
    dir_load = $onehot(direction) &&
               (dir_cand != (heading_q ^ 2'b01));
  end

  // wall flags an edge crossing; the wrapped coordinate is used when WRAP=1.
  always_comb begin
    nx   = seg_x[0];
    ny   = seg_y[0];
    wall = 1'b0;
    unique case (heading_q)
      H_UP: begin
        wall = (seg_y[0] == '0);
        ny   = wall ? YW'(GRID_H - 1) : seg_y[0] - YW'(1);
      end
      H_DOWN: begin
        wall = (seg_y[0] == YW'(GRID_H - 1));
        ny   = wall ? '0 : seg_y[0] + YW'(1);
      end
      H_LEFT: begin
        wall = (seg_x[0] == '0);
        nx   = wall ? XW'(GRID_W - 1) : seg_x[0] - XW'(1);
      end
      H_RIGHT: begin
        wall = (seg_x[0] == XW'(GRID_W - 1));
        nx   = wall ? '0 : seg_x[0] + XW'(1);
      end
      default: ;
    endcase
  end

  // The tail vacates its cell on a plain move, so it only counts as an
  // obstacle when the snake is growing.
  always_comb begin
    body_hit  = 1'b0;
    cand_hit  = 1'b0;
    query_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(snake_length)) begin
        if (seg_x[i] == cand_x && seg_y[i] == cand_y)
          cand_hit = 1'b1;
        if (seg_x[i] == query_x && seg_y[i] == query_y)
          query_hit = 1'b1;
        if (seg_x[i] == nx && seg_y[i] == ny &&
            (eat || i < int'(snake_length) - 1))
          body_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    lfsr_q      <= lfsr_nx;
    move_strobe <= 1'b0;
    q_snake     <= query_hit;
    q_head      <= (query_x == seg_x[0]) && (query_y == seg_y[0]);
    q_food      <= (query_x == food_x) && (query_y == food_y);
    if (dir_load)
      heading_q <= dir_cand;

    unique case (state_q)
      S_IDLE: begin
        if (start)
          state_q <= S_RUN;
      end
      S_RUN: begin
        cnt_q  <= tick ? '0 : cnt_q + CW'(1);
        pend_q <= 1'b0;
        if (tick || pend_q) begin
          if ((wall && !WRAP) || body_hit) begin
            state_q <= S_OVER;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x[i] <= seg_x[i-1];
              seg_y[i] <= seg_y[i-1];
            end
            seg_x[0]    <= nx;
            seg_y[0]    <= ny;
            move_strobe <= 1'b1;
            if (eat) begin
              if (snake_length != LW'(MAX_LEN))
                snake_length <= snake_length + LW'(1);
              score   <= score + 16'd1;
              state_q <= S_PLACE;
            end
          end
        end
      end
      S_PLACE: begin
        cnt_q <= tick ? '0 : cnt_q + CW'(1);
        if (tick)
          pend_q <= 1'b1;
        if (board_full) begin
          state_q <= S_OVER;
        end else if (cand_ok) begin
          food_x  <= cand_x;
          food_y  <= cand_y;
          state_q <= S_RUN;
        end
      end
      S_OVER: begin
        if (start)
          state_q <= S_RUN;
      end
      default: state_q <= S_IDLE;
    endcase

    // Restart rebuilds the playfield but keeps the LFSR running.
    if (reset || restart) begin
      heading_q    <= H_RIGHT;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      snake_length <= LW'(1);
      score        <= '0;
      food_x       <= XW'(GRID_W / 4);
      food_y       <= YW'(GRID_H / 4);
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= XW'(GRID_W / 2);
        seg_y[i] <= YW'(GRID_H / 2);
      end
    end

    if (reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      q_snake     <= 1'b0;
      q_head      <= 1'b0;
      q_food      <= 1'b0;
      move_strobe <= 1'b0;
    end
  end

endmodule
